// File: rtl/spi_frame_slave_pkg.sv
// Shared definitions for the SPI command-frame slave and the debug/bus bridge
// that consumes its frames: default widths, frame field positions, FSM codes.
package spi_frame_slave_pkg;

    localparam int SPI_OUT_W = 72;
    localparam int SPI_IN_W  = 40;

    // Field positions inside spi_out, as decoded by the bridge
    localparam int ADDR_MSB    = 71;
    localparam int ADDR_LSB    = 40;
    localparam int DATA_MSB    = 39;
    localparam int DATA_LSB    = 8;
    localparam int WE_BIT      = 3;
    localparam int START_BIT   = 2;
    localparam int SYS_RST_BIT = 1;
    localparam int CPU_RST_BIT = 0;

    // Same layout as a packed struct, for consumers that prefer named fields
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rsvd;
        logic        we;
        logic        start;
        logic        sys_rst;
        logic        cpu_rst;
    } spi_cmd_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_frame_slave_sync_edge.sv
// N-stage synchroniser for an asynchronous input with single-cycle rise/fall
// pulses. Edges are masked until the chain has flushed after reset, so a line
// already sitting away from its idle level at reset release does not produce
// a spurious edge.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   armed_q;

    // Synchroniser chain, one delayed copy for edge detect, flush tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            armed_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            prev_q  <= sync_q[STAGES-1];
            armed_q <= {armed_q[STAGES-1:0], 1'b1};
        end
    end

    assign rise_o = armed_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = armed_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave: oversamples SCLK/CS_N/MOSI in the clk domain, shifts in an
// OUT_W-bit command frame that is committed atomically to spi_out on CS_N
// rise, and streams an IN_W-bit readback word out on MISO, MSB first.
module spi_frame_slave
    import spi_frame_slave_pkg::*;
#(
    parameter int OUT_W       = SPI_OUT_W,
    parameter int IN_W        = SPI_IN_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             spi_reset,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [IN_W-1:0]  spi_in,
    output logic [OUT_W-1:0] spi_out,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int              CNT_W    = $clog2(OUT_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(OUT_W + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_sync;

    logic [0:0]       state_q, state_d;
    logic [OUT_W-1:0] rx_q, rx_d;
    logic [IN_W-1:0]  tx_q, tx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             miso_q, miso_d;
    logic             oe_q, oe_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (spi_reset),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (spi_reset),
        .d_i    (cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI only needs a level; same depth as SCLK keeps it aligned with sclk_rise
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

    // Frame FSM: the SCLK shift is applied before the commit decision so a
    // final rise coinciding with CS_N rise still counts toward the frame
    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                tx_d    = spi_in;
                cnt_d   = '0;
                miso_d  = spi_in[IN_W-1];
                oe_d    = 1'b1;
                state_d = ST_ACTIVE;
            end
        end else begin
            if (sclk_rise) begin
                rx_d = {rx_q[OUT_W-2:0], mosi_sync};
                if (cnt_q != CNT_OVER) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (sclk_fall) begin
                tx_d   = tx_q << 1;
                miso_d = tx_q[IN_W-2];
            end
            if (cs_rise) begin
                if (cnt_d == CNT_FULL) begin
                    out_d  = rx_d;
                    done_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
                oe_d    = 1'b0;
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    // Frame state and output registers
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            state_q <= ST_IDLE;
            rx_q    <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = oe_q;
    assign spi_out    = out_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
